// File: rtl/signmag_add_arbiter.sv
// signmag_add_arbiter: two requesters share one registered sign-magnitude
// adder through a round-robin arbiter. Each result goes back with the ID of
// the requester that produced it.
// Optional feature: define SIGNMAG_OVF_EN to add the res_ovf output, which
// reports the carry-out of a same-sign magnitude add.

// Combinational sign-magnitude adder (bit N-1 = sign, N-2..0 = magnitude).
module signmag_add_core #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);
    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;
    logic [N-2:0] w_max;
    logic [N-2:0] w_min;
    logic         w_sign;
    logic         w_same;
    logic [N-1:0] w_add;
    logic [N-2:0] w_sub;

    assign w_ma   = i_a[N-2:0];
    assign w_mb   = i_b[N-2:0];
    assign w_same = (i_a[N-1] == i_b[N-1]);

    // Order the magnitudes. A tie takes B's sign, so +x + -x gives -0
    // when B is the negative operand. Negative zero is not normalised.
    always_comb begin
        if (w_ma > w_mb) begin
            w_max  = w_ma;
            w_min  = w_mb;
            w_sign = i_a[N-1];
        end else begin
            w_max  = w_mb;
            w_min  = w_ma;
            w_sign = i_b[N-1];
        end
    end

    // Add one extra bit so the carry-out is visible. The magnitude itself wraps.
    assign w_add   = {1'b0, w_max} + {1'b0, w_min};
    assign w_sub   = w_max - w_min;
    assign o_sum   = {w_sign, (w_same ? w_add[N-2:0] : w_sub)};
    assign o_carry = w_same & w_add[N-1];
endmodule

module signmag_add_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id
`ifdef SIGNMAG_OVF_EN
    ,
    output logic         res_ovf
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_id;
    logic         r_last_grant;
    logic [N-1:0] r_res_data;
    logic         r_res_id;
    logic         r_res_valid;
    logic         w_grant;
    logic         w_idle;
    logic         w_hs;
    logic [N-1:0] w_sum;
    logic         w_carry;

    // Round-robin pick: a single valid requester wins outright. When both
    // are valid, the winner is the one not granted last time.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid)
            w_grant = ~r_last_grant;
        else if (req1_valid)
            w_grant = 1'b1;
    end

    // Readys are high only in IDLE, so a result consumed this cycle cannot
    // open a path from res_ready to reqX_ready.
    assign w_idle     = (r_state == IDLE);
    assign req0_ready = w_idle && !w_grant && req0_valid;
    assign req1_ready = w_idle &&  w_grant && req1_valid;
    assign w_hs       = req0_ready | req1_ready;

    // Next state: accept -> one compute cycle -> hold until consumed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = CALC;
            CALC:    w_next = HOLD;
            HOLD:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture the granted operands and ID on the handshake edge. After reset,
    // last_grant is 1, so requester 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_a          <= w_grant ? req1_a : req0_a;
            r_b          <= w_grant ? req1_b : req0_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    signmag_add_core #(.N(N)) u_core (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Register the result in CALC. Clear valid when the consumer takes it in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (r_state == CALC) begin
            r_res_data  <= w_sum;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
        end else if (r_state == HOLD && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

`ifdef SIGNMAG_OVF_EN
    logic r_res_ovf;

    // Overflow flag is captured with the data and stays stable through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_res_ovf <= 1'b0;
        else if (r_state == CALC)  r_res_ovf <= w_carry;
    end

    assign res_ovf = r_res_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_carry;
`endif
endmodule

// File: tb/tb_signmag_add_arbiter.sv
// Self-checking bench for signmag_add_arbiter. The reference model is a
// scoreboard of "pending result" plus integer sign-magnitude arithmetic.
// Define SIGNMAG_OVF_EN to also check res_ovf.
module tb_signmag_add_arbiter;
    localparam int N  = 4;
    localparam int MW = N - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic         req0_ready, req1_ready, res_valid, res_id;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [N-1:0] res_data;
`ifdef SIGNMAG_OVF_EN
    logic         res_ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    signmag_add_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
`ifdef SIGNMAG_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    // Model state: is a result owed, has the compute cycle passed, and what is it.
    bit           m_pend, m_done, m_last, m_id, m_ovf;
    logic [N-1:0] m_data;
    bit           last_e0, last_e1;
    logic [N-1:0] last_data;
    bit           last_id, last_ovf;
    int           got_ids[$];
    bit           h0, h1, v0, v1;
    logic [N-1:0] a0, b0, a1, b1;

    // Reference sum from the arithmetic rules, worked on integers.
    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
        int ma, mb, mag;
        bit sa, sb, s, o;
        ma = int'(a[N-2:0]); mb = int'(b[N-2:0]);
        sa = a[N-1];         sb = b[N-1];
        if (sa == sb) begin
            mag = ma + mb;
            o   = (mag >= (1 << MW));
            mag = mag % (1 << MW);
            s   = sa;
        end else begin
            mag = (ma > mb) ? ma - mb : mb - ma;
            s   = (ma > mb) ? sa : sb;
            o   = 1'b0;
        end
        return {o, s, mag[MW-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, then advance the model.
    task automatic step(input bit iv0, input logic [N-1:0] ia0, input logic [N-1:0] ib0,
                        input bit iv1, input logic [N-1:0] ia1, input logic [N-1:0] ib1,
                        input bit rr);
        bit g, e0, e1, ev;
        logic [N:0] r;
        req0_valid = iv0; req0_a = ia0; req0_b = ib0;
        req1_valid = iv1; req1_a = ia1; req1_b = ib1;
        res_ready  = rr;
        @(negedge clk);
        e0 = 1'b0; e1 = 1'b0;
        if (!m_pend) begin
            g  = (iv0 && iv1) ? !m_last : iv1;
            e0 = iv0 && !g;
            e1 = iv1 && g;
        end
        ev = m_pend && m_done;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("res_valid",  32'(res_valid),  32'(ev));
        if (ev) begin
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_id",   32'(res_id),   32'(m_id));
`ifdef SIGNMAG_OVF_EN
            chk("res_ovf",  32'(res_ovf),  32'(m_ovf));
            last_ovf = res_ovf;
`endif
            last_data = res_data;
            last_id   = res_id;
            if (rr) got_ids.push_back(int'(res_id));
        end
        if (e0 || e1) begin
            r      = e1 ? ref_add(ia1, ib1) : ref_add(ia0, ib0);
            m_ovf  = r[N];
            m_data = r[N-1:0];
            m_pend = 1'b1; m_done = 1'b0;
            m_last = e1;   m_id   = e1;
        end else if (m_pend && !m_done) begin
            m_done = 1'b1;
        end else if (ev && rr) begin
            m_pend = 1'b0;
        end
        last_e0 = e0; last_e1 = e1;
        @(posedge clk); #1;
    endtask

    // Requesters obey the hold rule: keep valid and operands until accepted.
    task automatic rand_step(input bit both, input bit rr);
        if (!h0) begin
            v0 = both || ($urandom_range(0, 1) == 1);
            a0 = N'($urandom()); b0 = N'($urandom());
        end
        if (!h1) begin
            v1 = both || ($urandom_range(0, 1) == 1);
            a1 = N'($urandom()); b1 = N'($urandom());
        end
        step(v0, a0, b0, v1, a1, b1, rr);
        h0 = v0 && !last_e0;
        h1 = v1 && !last_e1;
    endtask

    // Assert reset between clock edges and check that outputs clear at once.
    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst res_valid",  32'(res_valid),  32'd0);
        chk("rst res_data",   32'(res_data),   32'd0);
        chk("rst res_id",     32'(res_id),     32'd0);
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
`ifdef SIGNMAG_OVF_EN
        chk("rst res_ovf",    32'(res_ovf),    32'd0);
`endif
        m_pend = 1'b0; m_done = 1'b0; m_last = 1'b1;
        h0 = 1'b0; h1 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N:0] r;
        // Pin the model with hand-computed values.
        r = ref_add(4'b0011, 4'b1101); chk("model +3-5",  32'(r), 32'b0_1010);
        r = ref_add(4'b0011, 4'b1011); chk("model tie B-", 32'(r), 32'b0_1000);
        r = ref_add(4'b1011, 4'b0011); chk("model tie B+", 32'(r), 32'b0_0000);
        r = ref_add(4'b0110, 4'b0011); chk("model ovf",    32'(r), 32'b1_0001);
        r = ref_add(4'b0001, 4'b0001); chk("model 1+1",    32'(r), 32'b0_0010);

        @(posedge clk); #1;
        do_reset();

        // Single request from requester 0: +3 + -5 = -2.
        step(1, 4'b0011, 4'b1101, 0, '0, '0, 1);
        chk("tp1 ready pulse", 32'(last_e0), 32'd1);
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        chk("tp1 data", 32'(last_data), 32'b1010);
        chk("tp1 id",   32'(last_id),   32'd0);

        // Tie with opposite signs: the result takes B's sign.
        step(0, '0, '0, 1, 4'b0011, 4'b1011, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        chk("tie neg0 data", 32'(last_data), 32'b1000);
        chk("tie neg0 id",   32'(last_id),   32'd1);
        step(0, '0, '0, 1, 4'b1011, 4'b0011, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        chk("tie pos0 data", 32'(last_data), 32'b0000);

        // Magnitude overflow wraps silently.
        step(1, 4'b0110, 4'b0011, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        chk("ovf data", 32'(last_data), 32'b0001);
`ifdef SIGNMAG_OVF_EN
        chk("ovf flag", 32'(last_ovf), 32'd1);
`endif
        step(1, 4'b0001, 4'b0001, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        chk("no-ovf data", 32'(last_data), 32'b0010);
`ifdef SIGNMAG_OVF_EN
        chk("no-ovf flag", 32'(last_ovf), 32'd0);
`endif

        // Backpressure: both requesters wait while the result is held.
        step(1, 4'b0101, 4'b0010, 0, '0, '0, 0);
        step(1, 4'b0001, 4'b0001, 1, 4'b1100, 4'b0001, 0);
        for (int i = 0; i < 5; i++) step(1, 4'b0001, 4'b0001, 1, 4'b1100, 4'b0001, 0);
        step(1, 4'b0001, 4'b0001, 1, 4'b1100, 4'b0001, 1);
        chk("bp data", 32'(last_data), 32'b0111);
        step(1, 4'b0001, 4'b0001, 1, 4'b1100, 4'b0001, 1);
        chk("bp next grant", 32'(last_e1), 32'd1);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, '0, '0, 1);

        // Round-robin with both requesters continuously valid.
        do_reset();
        got_ids.delete();
        for (int i = 0; i < 14; i++) rand_step(1, 1);
        chk("rr count>=4", 32'(got_ids.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            chk("rr id seq", (i < got_ids.size()) ? 32'(got_ids[i]) : 32'd99, 32'(i % 2));

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) rand_step(0, $urandom_range(0, 9) < 7);

        // Reset during CALC.
        for (int i = 0; i < 6; i++) step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 1, 4'b0111, 4'b0111, 1);
        do_reset();
        step(1, 4'b0010, 4'b0001, 1, 4'b0100, 4'b0001, 1);
        chk("post-rst grant0", 32'(last_e0), 32'd1);
        for (int i = 0; i < 4; i++) step(0, '0, '0, 0, '0, '0, 1);

        // Reset during HOLD.
        step(0, '0, '0, 1, 4'b0011, 4'b0001, 0);
        step(0, '0, '0, 0, '0, '0, 0);
        chk("hold before rst", 32'(res_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, '0, '0, 1);
        step(1, 4'b0001, 4'b0010, 1, 4'b0001, 4'b0011, 1);
        chk("post-rst2 grant0", 32'(last_e0), 32'd1);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, '0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
